mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single 32-bit-address / 16-bit-data memory port between the CPU core and a secondary bus master (DMA/video).
- CPU writes are posted into a small write buffer, because the core never stalls on writes. CPU reads stall via cpu_ready until the memory returns data.
- Round-robin arbitration between the CPU side and the DMA side; one memory access is outstanding at a time.

Parameters:
- N, 32, address width
- M, 16, data width
- WBUF_DEPTH, 4, posted-write buffer entries (power of 2, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_addr  in  N  CPU address
- cpu_wdata  in  M  CPU write data
- cpu_re  in  1  CPU read request, held until cpu_ready
- cpu_we  in  1  CPU write strobe, one cycle per write, never stalled
- cpu_rdata  out  M  CPU read data, valid when cpu_ready
- cpu_ready  out  1  CPU read complete
- dma_addr  in  N  DMA address
- dma_wdata  in  M  DMA write data
- dma_re  in  1  DMA read request, held until dma_ready
- dma_we  in  1  DMA write request, held until dma_ready
- dma_rdata  out  M  DMA read data, valid when dma_ready
- dma_ready  out  1  DMA access complete, one-cycle pulse
- mem_addr  out  N  memory address
- mem_wdata  out  M  memory write data
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_rdata  in  M  memory read data
- mem_ready  in  1  memory access complete, may be high in the same cycle as the enable
- wbuf_overflow  out  1  sticky: a CPU write arrived while the buffer was full
- wbuf_empty  out  1  write buffer empty

Behaviour:
- Reset state, with rst low, asynchronous: FSM=IDLE, buffer empty, last_grant=DMA so the CPU side wins first. All outputs are 0 except wbuf_empty=1. Asserting reset mid-access aborts the access, drops buffered writes and clears wbuf_overflow.
- Write buffer:
  - cpu_we pushes {cpu_addr, cpu_wdata} at the clock edge if not full.
  - If full, the write is dropped and wbuf_overflow is set; only reset clears it.
  - A push and a pop in the same cycle are legal while full: the pop frees the slot and the push is accepted.
  - cpu_re and cpu_we asserted together: the push occurs and the read is treated as a new request.
- FSM states:
  - IDLE: mem_re=mem_we=0. Picks the next grant, registered, so the first memory enable appears the cycle after a request is seen in IDLE.
    - CPU-side candidate: buffer non-empty gives WB_WR; otherwise cpu_re gives CPU_RD.
    - DMA candidate: dma_re or dma_we gives DMA_ACC.
    - If both candidates exist, grant the side not in last_grant. If only one exists, grant it. If none, stay in IDLE.
  - WB_WR: mem_addr/mem_wdata = buffer head, mem_we=1. On mem_ready: pop, last_grant=CPU, go to IDLE.
  - CPU_RD: mem_addr=cpu_addr, mem_re=1. On mem_ready: cpu_ready=1 and cpu_rdata=mem_rdata (combinational pass-through, same cycle), last_grant=CPU, go to IDLE.
  - DMA_ACC: mem_addr=dma_addr, mem_wdata=dma_wdata, mem_re=dma_re, mem_we=dma_we (captured at grant). On mem_ready: dma_ready=1, dma_rdata=mem_rdata, last_grant=DMA, go to IDLE.
- Ordering:
  - A CPU read is never granted while the buffer is non-empty, so reads observe all earlier CPU writes.
  - Buffer drain order is FIFO.
- cpu_ready and dma_ready are 0 outside their completing cycle. cpu_rdata and dma_rdata are 0 when their ready is low.
- Minimum access time is 2 cycles (IDLE + grant state with mem_ready=1). No back-to-back grants without an IDLE cycle.
- Pointers wrap modulo WBUF_DEPTH. The count is tracked with one extra bit to distinguish full from empty.
- Requesters must hold address and data stable until ready. Dropping a request mid-access is a protocol violation and the access still completes.

Test Plan:
- Reset, then a CPU read of 0x00001234 with mem_ready returned 2 cycles after mem_re -> mem_re high for 3 cycles; cpu_ready one-cycle pulse with cpu_rdata = mem_rdata (e.g. 0xBEEF); FSM back in IDLE.
- CPU writes to 0x10/0x11/0x12 on consecutive cycles, mem_ready=1 always -> wbuf_empty falls; three mem_we accesses in order with data 0xA,0xB,0xC; wbuf_empty rises after the third.
- Five back-to-back CPU writes with mem_ready held low -> the fifth write is dropped; wbuf_overflow=1 and stays 1 until reset; after mem_ready rises, exactly 4 writes drain.
- CPU write then immediate cpu_re to the same address -> mem_we for the write precedes mem_re for the read; the read returns the written value from the memory model.
- cpu_re and dma_re held continuously, mem_ready=1 -> grants alternate CPU, DMA, CPU, DMA; each side's ready pulses every 4 cycles.
- rst asserted low during DMA_ACC with 2 writes buffered -> outputs clear immediately; after release wbuf_empty=1, wbuf_overflow=0, and the first grant goes to a pending CPU read.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory port between a CPU (posted writes, stalled reads) and a DMA master
module mem_bus_arbiter #(
    parameter int N          = 32,
    parameter int M          = 16,
    parameter int WBUF_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] cpu_addr,
    input  logic [M-1:0] cpu_wdata,
    input  logic         cpu_re,
    input  logic         cpu_we,
    output logic [M-1:0] cpu_rdata,
    output logic         cpu_ready,
    input  logic [N-1:0] dma_addr,
    input  logic [M-1:0] dma_wdata,
    input  logic         dma_re,
    input  logic         dma_we,
    output logic [M-1:0] dma_rdata,
    output logic         dma_ready,
    output logic [N-1:0] mem_addr,
    output logic [M-1:0] mem_wdata,
    output logic         mem_re,
    output logic         mem_we,
    input  logic [M-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic         wbuf_overflow,
    output logic         wbuf_empty
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(WBUF_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WB_WR   = 2'd1;
    localparam logic [1:0] S_CPU_RD  = 2'd2;
    localparam logic [1:0] S_DMA_ACC = 2'd3;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DMA = 1'b1;

    logic [1:0]    state;
    logic          last_grant;

    logic [N-1:0]  wb_addr [WBUF_DEPTH];
    logic [M-1:0]  wb_data [WBUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          push;
    logic          pop;
    logic          overflow_q;

    logic [N-1:0]  dma_addr_q;
    logic [M-1:0]  dma_wdata_q;
    logic          dma_re_q;
    logic          dma_we_q;

    logic          wb_cand;
    logic          cpu_cand;
    logic          dma_cand;

    assign full       = (count == FULL_COUNT);
    assign wbuf_empty = (count == '0);
    assign pop        = (state == S_WB_WR) && mem_ready;
    // A pop in the same cycle frees a slot, so a write arriving while full is still accepted.
    assign push       = cpu_we && (!full || pop);
    assign wbuf_overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[wr_ptr] <= cpu_addr;
            wb_data[wr_ptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
            if (cpu_we && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // A write arriving this cycle counts as buffered so a simultaneous read cannot overtake it.
    assign wb_cand  = !wbuf_empty || cpu_we;
    assign cpu_cand = wb_cand || cpu_re;
    assign dma_cand = dma_re || dma_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            last_grant  <= GRANT_DMA;
            dma_addr_q  <= '0;
            dma_wdata_q <= '0;
            dma_re_q    <= 1'b0;
            dma_we_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_cand && (!dma_cand || last_grant == GRANT_DMA)) begin
                        state <= wb_cand ? S_WB_WR : S_CPU_RD;
                    end else if (dma_cand) begin
                        state       <= S_DMA_ACC;
                        dma_addr_q  <= dma_addr;
                        dma_wdata_q <= dma_wdata;
                        dma_re_q    <= dma_re;
                        dma_we_q    <= dma_we;
                    end
                end
                S_WB_WR, S_CPU_RD: begin
                    if (mem_ready) begin
                        state      <= S_IDLE;
                        last_grant <= GRANT_CPU;
                    end
                end
                S_DMA_ACC: begin
                    if (mem_ready) begin
                        state      <= S_IDLE;
                        last_grant <= GRANT_DMA;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        dma_ready = 1'b0;
        dma_rdata = '0;
        case (state)
            S_WB_WR: begin
                mem_addr  = wb_addr[rd_ptr];
                mem_wdata = wb_data[rd_ptr];
                mem_we    = 1'b1;
            end
            S_CPU_RD: begin
                mem_addr = cpu_addr;
                mem_re   = 1'b1;
                if (mem_ready) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = mem_rdata;
                end
            end
            S_DMA_ACC: begin
                mem_addr  = dma_addr_q;
                mem_wdata = dma_wdata_q;
                mem_re    = dma_re_q;
                mem_we    = dma_we_q;
                if (mem_ready) begin
                    dma_ready = 1'b1;
                    dma_rdata = mem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with a small memory model
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, dma_addr, mem_addr;
    logic [15:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic        cpu_re, cpu_we, cpu_ready, dma_re, dma_we, dma_ready;
    logic        mem_re, mem_we, mem_ready, wbuf_overflow, wbuf_empty;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] model [256];
    bit          mvalid [256];
    int          ready_delay = 0;
    bit          hold_ready  = 1'b0;
    int          wait_cnt    = 0;

    typedef struct {
        logic [31:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_cpu[$];
    logic [15:0] exp_dma[$];
    int          grant_log[$];
    int          cpu_rdy_cyc[$];
    int          dma_rdy_cyc[$];
    int          writes_seen = 0;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_re(dma_re), .dma_we(dma_we),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .wbuf_overflow(wbuf_overflow), .wbuf_empty(wbuf_empty)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dflt(input logic [31:0] a);
        return a[15:0] ^ 16'hACDB;
    endfunction

    assign mem_ready = (mem_re || mem_we) && !hold_ready && (wait_cnt >= ready_delay);
    assign mem_rdata = !mem_re ? 16'h0 :
                       (mvalid[mem_addr[7:0]] ? model[mem_addr[7:0]] : dflt(mem_addr));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((mem_re || mem_we) && !mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (mem_we && mem_ready) begin
            model[mem_addr[7:0]]  <= mem_wdata;
            mvalid[mem_addr[7:0]] <= 1'b1;
        end
    end

    // Scoreboard: completed memory transactions are matched against expectations queued at stimulus time.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_we && mem_ready && !dma_ready) begin
                wr_t w;
                writes_seen = writes_seen + 1;
                grant_log.push_back(0);
                total++;
                if (exp_wr.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected got=%h/%h want=none", mem_addr, mem_wdata);
                end else begin
                    w = exp_wr.pop_front();
                    if (mem_addr !== w.a || mem_wdata !== w.d) begin
                        bad++;
                        $display("FAIL wr_order got=%h/%h want=%h/%h", mem_addr, mem_wdata, w.a, w.d);
                    end
                end
            end
            total++;
            if (cpu_ready) begin
                grant_log.push_back(1);
                cpu_rdy_cyc.push_back(cyc);
                if (exp_cpu.size() == 0) begin
                    bad++;
                    $display("FAIL cpu_rd_unexpected got=%h want=none", cpu_rdata);
                end else if (cpu_rdata !== exp_cpu[0]) begin
                    bad++;
                    $display("FAIL cpu_rdata got=%h want=%h", cpu_rdata, exp_cpu[0]);
                end
                if (exp_cpu.size() != 0) void'(exp_cpu.pop_front());
            end else if (cpu_rdata !== 16'h0) begin
                bad++;
                $display("FAIL cpu_rdata_idle got=%h want=0", cpu_rdata);
            end
            total++;
            if (dma_ready) begin
                grant_log.push_back(2);
                dma_rdy_cyc.push_back(cyc);
                if (exp_dma.size() == 0) begin
                    bad++;
                    $display("FAIL dma_rd_unexpected got=%h want=none", dma_rdata);
                end else if (dma_rdata !== exp_dma[0]) begin
                    bad++;
                    $display("FAIL dma_rdata got=%h want=%h", dma_rdata, exp_dma[0]);
                end
                if (exp_dma.size() != 0) void'(exp_dma.pop_front());
            end else if (dma_rdata !== 16'h0) begin
                bad++;
                $display("FAIL dma_rdata_idle got=%h want=0", dma_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [15:0] d, input bit expect_accept);
        wr_t w;
        w.a = a;
        w.d = d;
        if (expect_accept) exp_wr.push_back(w);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, input logic [15:0] e, output int nre, output bit done);
        nre  = 0;
        done = 1'b0;
        cpu_addr = a;
        cpu_re   = 1'b1;
        exp_cpu.push_back(e);
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (mem_re) nre++;
            if (cpu_ready) done = 1'b1;
        end
        tick();
        cpu_re = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_re = 0; cpu_we = 0;
        dma_addr = '0; dma_wdata = '0; dma_re = 0; dma_we = 0;
        repeat (3) tick();
        total++;
        if ({mem_re, mem_we, cpu_ready, dma_ready} !== 4'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=0000", {mem_re, mem_we, cpu_ready, dma_ready});
        end
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 16'h0) begin
            bad++;
            $display("FAIL reset_bus got=%h/%h want=0/0", mem_addr, mem_wdata);
        end
        total++;
        if (wbuf_empty !== 1'b1 || wbuf_overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got=empty%b/ovf%b want=empty1/ovf0", wbuf_empty, wbuf_overflow);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read();
        int n;
        bit done;
        ready_delay = 2;
        cpu_read(32'h0000_1234, dflt(32'h0000_1234), n, done);
        total++;
        if (!done) begin
            bad++;
            $display("FAIL cpu_read_timeout got=0 want=1");
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL cpu_read_re_cycles got=%0d want=3", n);
        end
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b0 || mem_re !== 1'b0) begin
            bad++;
            $display("FAIL cpu_read_idle got=rdy%b/re%b want=0/0", cpu_ready, mem_re);
        end
        ready_delay = 0;
        tick();
    endtask

    task automatic test_write_drain();
        int base = writes_seen;
        bit seen_empty = 1'b0;
        cpu_write(32'h10, 16'hA, 1'b1);
        total++;
        if (wbuf_empty !== 1'b0) begin
            bad++;
            $display("FAIL drain_empty_fall got=%b want=0", wbuf_empty);
        end
        cpu_write(32'h11, 16'hB, 1'b1);
        cpu_write(32'h12, 16'hC, 1'b1);
        for (int k = 0; k < 30 && !seen_empty; k++) begin
            @(negedge clk);
            if (wbuf_empty) seen_empty = 1'b1;
        end
        total++;
        if (!seen_empty || writes_seen - base != 3) begin
            bad++;
            $display("FAIL drain_count got=%0d want=3", writes_seen - base);
        end
        tick();
        total++;
        if (exp_wr.size() != 0) begin
            bad++;
            $display("FAIL drain_left got=%0d want=0", exp_wr.size());
        end
    endtask

    task automatic test_overflow();
        int base = writes_seen;
        bit seen_empty = 1'b0;
        hold_ready = 1'b1;
        for (int i = 0; i < 4; i++) cpu_write(32'h20 + i, 16'h100 + 16'(i), 1'b1);
        total++;
        if (wbuf_overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_early got=%b want=0", wbuf_overflow);
        end
        cpu_write(32'h24, 16'h104, 1'b0);
        total++;
        if (wbuf_overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set got=%b want=1", wbuf_overflow);
        end
        hold_ready = 1'b0;
        for (int k = 0; k < 40 && !seen_empty; k++) begin
            @(negedge clk);
            if (wbuf_empty) seen_empty = 1'b1;
        end
        tick();
        total++;
        if (!seen_empty || writes_seen - base != 4) begin
            bad++;
            $display("FAIL ovf_drain got=%0d want=4", writes_seen - base);
        end
        total++;
        if (wbuf_overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky got=%b want=1", wbuf_overflow);
        end
    endtask

    task automatic test_write_then_read();
        int n;
        bit done;
        grant_log.delete();
        cpu_write(32'h40, 16'h5A5A, 1'b1);
        cpu_read(32'h40, 16'h5A5A, n, done);
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wr_rd_timeout got=0 want=1");
        end
        total++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
            bad++;
            $display("FAIL wr_rd_order got=%p want=write,read", grant_log);
        end
    endtask

    task automatic test_round_robin();
        bit alt = 1'b1;
        bit gap = 1'b1;
        grant_log.delete();
        cpu_rdy_cyc.delete();
        dma_rdy_cyc.delete();
        cpu_addr = 32'h50;
        dma_addr = 32'h60;
        cpu_re = 1'b1;
        dma_re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_cpu.push_back(dflt(32'h50));
            exp_dma.push_back(dflt(32'h60));
        end
        repeat (16) @(negedge clk);
        tick();
        cpu_re = 1'b0;
        dma_re = 1'b0;
        tick();
        for (int i = 1; i < grant_log.size(); i++)
            if (grant_log[i] == grant_log[i-1]) alt = 1'b0;
        total++;
        if (grant_log.size() != 8 || !alt) begin
            bad++;
            $display("FAIL rr_alternate got=%p want=8 alternating", grant_log);
        end
        for (int i = 1; i < cpu_rdy_cyc.size(); i++)
            if (cpu_rdy_cyc[i] - cpu_rdy_cyc[i-1] != 4) gap = 1'b0;
        for (int i = 1; i < dma_rdy_cyc.size(); i++)
            if (dma_rdy_cyc[i] - dma_rdy_cyc[i-1] != 4) gap = 1'b0;
        total++;
        if (cpu_rdy_cyc.size() != 4 || dma_rdy_cyc.size() != 4 || !gap) begin
            bad++;
            $display("FAIL rr_period got=cpu%p dma%p want=4 each every 4", cpu_rdy_cyc, dma_rdy_cyc);
        end
        total++;
        if (exp_cpu.size() != 0 || exp_dma.size() != 0) begin
            bad++;
            $display("FAIL rr_left got=%0d/%0d want=0/0", exp_cpu.size(), exp_dma.size());
        end
    endtask

    task automatic test_reset_mid();
        bit c_done = 1'b0;
        bit d_done = 1'b0;
        hold_ready = 1'b1;
        dma_addr = 32'h60;
        dma_re = 1'b1;
        cpu_addr = 32'h70; cpu_wdata = 16'h7; cpu_we = 1'b1;
        tick();
        cpu_addr = 32'h71; cpu_wdata = 16'h8;
        tick();
        cpu_we = 1'b0;
        total++;
        if (mem_re !== 1'b1 || mem_addr !== 32'h60 || wbuf_empty !== 1'b0) begin
            bad++;
            $display("FAIL mid_setup got=re%b/%h/empty%b want=1/60/0", mem_re, mem_addr, wbuf_empty);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({mem_re, mem_we, dma_ready, cpu_ready} !== 4'b0 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL mid_abort got=%b/%h want=0000/0", {mem_re, mem_we, dma_ready, cpu_ready}, mem_addr);
        end
        total++;
        if (wbuf_empty !== 1'b1 || wbuf_overflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_flags got=empty%b/ovf%b want=1/0", wbuf_empty, wbuf_overflow);
        end
        tick();
        rst = 1'b1;
        hold_ready = 1'b0;
        grant_log.delete();
        cpu_addr = 32'h50;
        cpu_re = 1'b1;
        exp_cpu.push_back(dflt(32'h50));
        exp_dma.push_back(dflt(32'h60));
        for (int k = 0; k < 30 && !(c_done && d_done); k++) begin
            @(negedge clk);
            if (cpu_ready) c_done = 1'b1;
            if (dma_ready) d_done = 1'b1;
            tick();
            if (c_done) cpu_re = 1'b0;
            if (d_done) dma_re = 1'b0;
        end
        total++;
        if (!c_done || !d_done) begin
            bad++;
            $display("FAIL mid_timeout got=%b%b want=11", c_done, d_done);
        end
        total++;
        if (grant_log.size() != 2 || grant_log[0] != 1) begin
            bad++;
            $display("FAIL mid_first_grant got=%p want=cpu first", grant_log);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_write_drain();
        test_overflow();
        test_write_then_read();
        test_round_robin();
        test_reset_mid();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
